seg7_scan_decoder: RTL and testbench
====================================

// Module: seg7_scan_decoder
// PURPOSE
//  Receive-side counterpart of the 7-segment hex encoder: samples a scanned,
//  multiplexed active-low display bus (anodes, a..g, dp) and rebuilds per-digit
//  hex nibbles. Delivers them as a frame snapshot with a valid/ack handshake.
//  Used for display loopback checking and for board-level self-test.
// PARAMETERS
//  DIGITS         8   number of scanned digits (an width); 2..8
//  STABLE_CYCLES  4   consecutive identical synced samples before capture; >=2
// PORTS
//  clk          in   1          system clock
//  rst_n        in   1          asynchronous reset, active low
//  an           in   DIGITS     digit selects, active low, async to clk
//  seg          in   7          {a,b,c,d,e,f,g}, active low, async to clk
//  dp           in   1          decimal point, active low, async to clk
//  frame_ack    in   1          consumer accepts the current snapshot
//  frame_valid  out  1          snapshot registers hold an unacked frame
//  hex_out      out  4*DIGITS   nibble i at [4i+3:4i]; digit 0 = an[0]
//  point_out    out  DIGITS     dp per digit, active high
//  blank_out    out  DIGITS     digit captured as all segments off
//  overrun      out  1          sticky; a frame completed while frame_valid=1 and no ack
//  err_seg      out  1          1-cycle pulse: undecodable segment pattern captured
//  err_sel      out  1          1-cycle pulse: stable select with >1 anode low
// BEHAVIOUR
//  - Reset: every output and internal register is 0. Async assert, sync deassert.
//  - an, seg, dp pass through 2-flop synchronisers. Compare vector = {an,seg,dp}.
//  - Stability counter: resets to 0 when the compare vector changes and increments
//    (saturating) while it is unchanged. Width is $clog2(STABLE_CYCLES+1).
//  - Capture fires exactly once per dwell, on the cycle the counter reaches
//    STABLE_CYCLES-1. Pin change to capture pulse = 2 + STABLE_CYCLES cycles.
//  - At capture, select classes: all anodes high gives no action. Exactly one low
//    selects digit i. More than one low pulses err_sel and captures nothing.
//  - Segment decode (active low a..g -> nibble). Any pattern not listed below
//    pulses err_seg and leaves digit i not captured.
//    0:0000001 1:1001111 2:0010010 3:0000110 4:1001100 5:0100100 6:0100000
//    7:0001111 8:0000000 9:0000100 A:0001000 b:1100000 C:0110001 d:1000010
//    E:0110000 F:0111000. Pattern 1111111 is blank: nibble 0, blank bit set.
//  - A valid capture writes the working registers for digit i (nibble, blank,
//    point) and sets collected[i]. Recapturing a digit overwrites it.
//  - Frame complete when collected is all ones. On the next cycle collected clears,
//    then one of:
//    . frame_valid=0: copy the working set to the outputs and set frame_valid=1.
//    . frame_valid=1, no ack: outputs hold, set overrun, discard the new frame.
//    . frame_valid=1 with ack in the same cycle: load the new frame, frame_valid
//      stays 1, overrun unchanged.
//  - frame_ack while frame_valid=1 and no completion: clear frame_valid and
//    overrun next cycle. frame_ack while frame_valid=0 is ignored.
//  - A bus that stops scanning leaves the outputs unchanged. A partial frame
//    persists until it completes or reset.
//  - Reset mid-frame: working set, collected, snapshot and flags return to 0.
// CONFIGURATION
//  SEG7_DP_CAPTURE_EN defined: dp is synchronised, included in the compare
//    vector, and captured into point_out (~dp).
//  Not defined: dp is ignored (no synchroniser, not compared) and point_out is 0.
// TESTING
//  1. Reset, then scan digits 0..7 with 3,0,1,2,5,A,F,blank, dwell 10 cycles
//     -> frame_valid=1, hex_out=32'h0FA52103, blank_out=8'h80, errors 0.
//  2. Hold an=8'hFE, seg=1001111 for 5 cycles (STABLE_CYCLES=4) -> exactly one
//     capture of digit 0 = 1, 6 cycles after the pin change. A 3-cycle dwell
//     captures nothing.
//  3. Drive an=8'hFC for 10 cycles -> one err_sel pulse, collected unchanged.
//     Drive seg=1111110 on a single anode -> one err_seg pulse.
//  4. Complete two frames with frame_ack low -> first snapshot retained,
//     overrun=1. Raise frame_ack -> frame_valid=0 and overrun=0 next cycle.
//  5. Assert frame_ack in the same cycle a frame completes -> new data loaded,
//     frame_valid stays 1, overrun stays 0.
//  6. With SEG7_DP_CAPTURE_EN, dp=0 on digit 2 gives point_out=8'h04. Without the
//     macro, point_out=0, and a dp toggle alone does not restart stability.
//     Pulse rst_n low mid-frame -> all outputs 0.

Source files
------------

// File: rtl/seg7_scan_decoder_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : seg7_scan_decoder_if                                          |
// | Purpose  : Bundles the scanned display bus (an, seg, dp) and the frame    |
// |            snapshot / handshake signals of seg7_scan_decoder.             |
// | Ports    : an[DIGITS], seg[7], dp, frame_ack      -> into the decoder     |
// |            frame_valid, hex_out[4*DIGITS], point_out[DIGITS],             |
// |            blank_out[DIGITS], overrun, err_seg, err_sel <- from decoder   |
// | Modports : master = display/consumer side, slave = decoder side          |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
interface seg7_scan_decoder_if #(
  parameter int DIGITS = 8
);
  logic [DIGITS-1:0]   an;
  logic [6:0]          seg;
  logic                dp;
  logic                frame_ack;
  logic                frame_valid;
  logic [4*DIGITS-1:0] hex_out;
  logic [DIGITS-1:0]   point_out;
  logic [DIGITS-1:0]   blank_out;
  logic                overrun;
  logic                err_seg;
  logic                err_sel;

  modport master (
    output an, seg, dp, frame_ack,
    input  frame_valid, hex_out, point_out, blank_out, overrun, err_seg, err_sel
  );

  modport slave (
    input  an, seg, dp, frame_ack,
    output frame_valid, hex_out, point_out, blank_out, overrun, err_seg, err_sel
  );
endinterface
`default_nettype wire

// File: rtl/seg7_scan_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : seg7_scan_decoder                                             |
// | Purpose  : Samples a multiplexed active-low 7-segment display bus and     |
// |            rebuilds per-digit hex nibbles into a frame snapshot that is   |
// |            handed to a consumer with a valid/ack handshake.               |
// | Ports    : clk, rst_n (async assert, sync deassert, active low)          |
// |            bus (seg7_scan_decoder_if.slave): an, seg, dp, frame_ack in;   |
// |            frame_valid, hex_out, point_out, blank_out, overrun,           |
// |            err_seg, err_sel out                                           |
// | Macro    : SEG7_DP_CAPTURE_EN - synchronise, compare and capture dp       |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module seg7_scan_decoder #(
  parameter int DIGITS        = 8,
  parameter int STABLE_CYCLES = 4
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  seg7_scan_decoder_if.slave bus
);

  localparam int c_cnt_w = $clog2(STABLE_CYCLES + 1);
`ifdef SEG7_DP_CAPTURE_EN
  localparam int c_vec_w = DIGITS + 8;
`else
  localparam int c_vec_w = DIGITS + 7;
`endif

  // Reset synchroniser: assertion propagates immediately, release is aligned to clk.
  logic [1:0] r_rst_sync;
  logic       w_rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rst_sync <= 2'b00;
    else        r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  // Two-flop synchronisers for the asynchronous display pins.
  logic [DIGITS-1:0] r_an_s1, r_an_s2;
  logic [6:0]        r_seg_s1, r_seg_s2;
  logic [c_vec_w-1:0] w_vec, r_prev;
`ifdef SEG7_DP_CAPTURE_EN
  logic r_dp_s1, r_dp_s2;

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_dp_s1 <= 1'b0;
      r_dp_s2 <= 1'b0;
    end else begin
      r_dp_s1 <= bus.dp;
      r_dp_s2 <= r_dp_s1;
    end
  end
  assign w_vec = {r_an_s2, r_seg_s2, r_dp_s2};
`else
  assign w_vec = {r_an_s2, r_seg_s2};
`endif

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_an_s1  <= '0;
      r_an_s2  <= '0;
      r_seg_s1 <= '0;
      r_seg_s2 <= '0;
    end else begin
      r_an_s1  <= bus.an;
      r_an_s2  <= r_an_s1;
      r_seg_s1 <= bus.seg;
      r_seg_s2 <= r_seg_s1;
    end
  end

  // Stability tracking. r_fill keeps the counter at zero until the synchroniser
  // pipeline and r_prev hold real pin samples, so the all-zero reset contents
  // (which look like "every anode selected") can never be captured.
  logic [c_cnt_w-1:0] r_cnt;
  logic [1:0]         r_fill;
  logic               w_same, w_capture;

  assign w_same    = (w_vec == r_prev);
  assign w_capture = (r_fill == 2'b11) && w_same &&
                     (r_cnt == c_cnt_w'(STABLE_CYCLES - 1));

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_prev <= '0;
      r_cnt  <= '0;
      r_fill <= 2'b00;
    end else begin
      r_prev <= w_vec;
      if (r_fill != 2'b11) r_fill <= r_fill + 2'd1;
      if ((r_fill != 2'b11) || !w_same) r_cnt <= '0;
      else if (r_cnt != {c_cnt_w{1'b1}}) r_cnt <= r_cnt + c_cnt_w'(1);
    end
  end

  // Capture decode works on r_prev, which equals w_vec whenever w_capture is set.
  logic [DIGITS-1:0] w_sel;
  logic [6:0]        w_cap_seg;
  logic              w_sel_one, w_sel_multi, w_seg_ok, w_write;
  logic [5:0]        w_dec;

  assign w_sel       = ~r_prev[c_vec_w-1 -: DIGITS];
  assign w_cap_seg   = r_prev[c_vec_w-DIGITS-1 -: 7];
  // Clearing the lowest set bit leaves something only if two or more were set.
  assign w_sel_multi = |(w_sel & (w_sel - DIGITS'(1)));
  assign w_sel_one   = (|w_sel) && !w_sel_multi;

  // Returns {recognised, blank, nibble}.
  function automatic logic [5:0] f_decode(input logic [6:0] s);
    case (s)
      7'b0000001: f_decode = 6'b10_0000;
      7'b1001111: f_decode = 6'b10_0001;
      7'b0010010: f_decode = 6'b10_0010;
      7'b0000110: f_decode = 6'b10_0011;
      7'b1001100: f_decode = 6'b10_0100;
      7'b0100100: f_decode = 6'b10_0101;
      7'b0100000: f_decode = 6'b10_0110;
      7'b0001111: f_decode = 6'b10_0111;
      7'b0000000: f_decode = 6'b10_1000;
      7'b0000100: f_decode = 6'b10_1001;
      7'b0001000: f_decode = 6'b10_1010;
      7'b1100000: f_decode = 6'b10_1011;
      7'b0110001: f_decode = 6'b10_1100;
      7'b1000010: f_decode = 6'b10_1101;
      7'b0110000: f_decode = 6'b10_1110;
      7'b0111000: f_decode = 6'b10_1111;
      7'b1111111: f_decode = 6'b11_0000;
      default:    f_decode = 6'b00_0000;
    endcase
  endfunction

  assign w_dec    = f_decode(w_cap_seg);
  assign w_seg_ok = w_dec[5];
  assign w_write  = w_capture && w_sel_one && w_seg_ok;

  // Working set, collected mask and error pulses.
  logic [4*DIGITS-1:0] r_work_hex;
  logic [DIGITS-1:0]   r_work_blank, r_collected;
  logic                r_err_seg, r_err_sel, w_complete;
`ifdef SEG7_DP_CAPTURE_EN
  logic [DIGITS-1:0]   r_work_point;
`endif

  assign w_complete = &r_collected;

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_work_hex   <= '0;
      r_work_blank <= '0;
      r_collected  <= '0;
      r_err_seg    <= 1'b0;
      r_err_sel    <= 1'b0;
`ifdef SEG7_DP_CAPTURE_EN
      r_work_point <= '0;
`endif
    end else begin
      r_err_sel   <= w_capture && w_sel_multi;
      r_err_seg   <= w_capture && w_sel_one && !w_seg_ok;
      r_collected <= (w_complete ? '0 : r_collected) | (w_write ? w_sel : '0);
      if (w_write) begin
        for (int i = 0; i < DIGITS; i++) begin
          if (w_sel[i]) begin
            r_work_hex[4*i +: 4] <= w_dec[3:0];
            r_work_blank[i]      <= w_dec[4];
`ifdef SEG7_DP_CAPTURE_EN
            r_work_point[i]      <= ~r_prev[0];
`endif
          end
        end
      end
    end
  end

  // Snapshot registers and handshake.
  logic [4*DIGITS-1:0] r_snap_hex;
  logic [DIGITS-1:0]   r_snap_blank;
  logic                r_frame_valid, r_overrun;
`ifdef SEG7_DP_CAPTURE_EN
  logic [DIGITS-1:0]   r_snap_point;
`endif

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_snap_hex    <= '0;
      r_snap_blank  <= '0;
      r_frame_valid <= 1'b0;
      r_overrun     <= 1'b0;
`ifdef SEG7_DP_CAPTURE_EN
      r_snap_point  <= '0;
`endif
    end else if (w_complete) begin
      // A same-cycle ack frees the snapshot, so the new frame may replace it.
      if (!r_frame_valid || bus.frame_ack) begin
        r_snap_hex    <= r_work_hex;
        r_snap_blank  <= r_work_blank;
        r_frame_valid <= 1'b1;
`ifdef SEG7_DP_CAPTURE_EN
        r_snap_point  <= r_work_point;
`endif
      end else begin
        r_overrun <= 1'b1;
      end
    end else if (bus.frame_ack && r_frame_valid) begin
      r_frame_valid <= 1'b0;
      r_overrun     <= 1'b0;
    end
  end

  assign bus.frame_valid = r_frame_valid;
  assign bus.hex_out     = r_snap_hex;
  assign bus.blank_out   = r_snap_blank;
  assign bus.overrun     = r_overrun;
  assign bus.err_seg     = r_err_seg;
  assign bus.err_sel     = r_err_sel;
`ifdef SEG7_DP_CAPTURE_EN
  assign bus.point_out   = r_snap_point;
`else
  assign bus.point_out   = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_seg7_scan_decoder                                          |
// | Purpose  : Directed self-checking bench for seg7_scan_decoder            |
// |            (DIGITS=8, STABLE_CYCLES=4).                                   |
// | Ports    : none                                                          |
// | Macro    : SEG7_DP_CAPTURE_EN selects the dp-capture expectations        |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_seg7_scan_decoder;
  localparam int DIGITS = 8;
  localparam int STABLE = 4;

  localparam logic [6:0] c_pbl = 7'b1111111;
  localparam logic [6:0] c_pbad = 7'b1111110;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seg7_scan_decoder_if #(.DIGITS(DIGITS)) bus ();

  seg7_scan_decoder #(
    .DIGITS       (DIGITS),
    .STABLE_CYCLES(STABLE)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Active-low a..g patterns for hex digits 0..F.
  logic [6:0] pat [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  int n_cmp = 0;
  int n_bad = 0;
  int n_sel = 0;
  int n_seg = 0;

  always @(negedge clk) begin
    if (bus.err_sel === 1'b1) n_sel++;
    if (bus.err_seg === 1'b1) n_seg++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic show(input int d, input logic [6:0] p, input int dwell);
    bus.an  = ~(8'h01 << d);
    bus.seg = p;
    step(dwell);
  endtask

  task automatic idle(input int n);
    bus.an  = 8'hFF;
    bus.seg = c_pbl;
    step(n);
  endtask

  task automatic scan_frame(input logic [31:0] v);
    for (int i = 0; i < DIGITS; i++) show(i, pat[v[4*i +: 4]], 10);
  endtask

  task automatic ack_pulse();
    bus.frame_ack = 1'b1;
    step(1);
    bus.frame_ack = 1'b0;
  endtask

  initial begin
    bus.an = 8'hFF;
    bus.seg = c_pbl;
    bus.dp = 1'b1;
    bus.frame_ack = 1'b0;
    step(3);
    check("rst_valid", bus.frame_valid, 0);
    check("rst_hex", bus.hex_out, 0);
    check("rst_blank", bus.blank_out, 0);
    check("rst_point", bus.point_out, 0);
    check("rst_overrun", bus.overrun, 0);
    check("rst_err_seg", bus.err_seg, 0);
    check("rst_err_sel", bus.err_sel, 0);
    rst_n = 1'b1;
    idle(10);

    // Basic frame with a blank digit
    show(0, pat[3], 10);  show(1, pat[0], 10);  show(2, pat[1], 10);
    show(3, pat[2], 10);  show(4, pat[5], 10);  show(5, pat[10], 10);
    show(6, pat[15], 10); show(7, c_pbl, 10);
    check("f1_valid", bus.frame_valid, 1);
    check("f1_hex", bus.hex_out, 32'h0FA52103);
    check("f1_blank", bus.blank_out, 32'h80);
    check("f1_point", bus.point_out, 0);
    check("f1_overrun", bus.overrun, 0);
    check("f1_err_sel_cnt", n_sel, 0);
    check("f1_err_seg_cnt", n_seg, 0);
    ack_pulse();
    check("ack1_valid", bus.frame_valid, 0);
    check("ack1_overrun", bus.overrun, 0);

    // Minimum dwell captures, a 3-cycle dwell does not
    show(0, pat[1], 5);
    for (int i = 1; i < 7; i++) show(i, pat[i + 3], 10);
    show(7, pat[12], 3);
    idle(10);
    check("short_dwell_valid", bus.frame_valid, 0);
    show(7, pat[12], 10);
    check("f2_valid", bus.frame_valid, 1);
    check("f2_hex", bus.hex_out, 32'hC9876541);
    check("f2_blank", bus.blank_out, 0);

    // Multi-anode select: pulse timing relative to the pin change
    bus.an  = 8'hFC;
    bus.seg = pat[8];
    step(6);
    check("sel_lat_t6", bus.err_sel, 0);
    step(1);
    check("sel_lat_t7", bus.err_sel, 1);
    step(1);
    check("sel_lat_t8", bus.err_sel, 0);
    step(2);
    check("sel_pulse_cnt", n_sel, 1);

    // Undecodable digit blocks completion; a second full frame then overruns
    show(0, pat[8], 10); show(1, pat[7], 10); show(2, pat[6], 10);
    show(3, c_pbad, 10); show(4, pat[4], 10); show(5, pat[3], 10);
    show(6, pat[2], 10); show(7, pat[1], 10);
    check("seg_pulse_cnt", n_seg, 1);
    check("seg_no_complete_ovr", bus.overrun, 0);
    show(3, pat[5], 10);
    check("ovr_set", bus.overrun, 1);
    check("ovr_valid", bus.frame_valid, 1);
    check("ovr_hex_held", bus.hex_out, 32'hC9876541);
    ack_pulse();
    check("ack2_valid", bus.frame_valid, 0);
    check("ack2_overrun", bus.overrun, 0);

    // Ack coinciding with frame completion
    scan_frame(32'h76543210);
    check("f3_valid", bus.frame_valid, 1);
    check("f3_hex", bus.hex_out, 32'h76543210);
    for (int i = 0; i < 7; i++) show(i, pat[(i + 10) % 16], 10);
    bus.an  = 8'h7F;
    bus.seg = pat[9];
    step(7);
    bus.frame_ack = 1'b1;
    step(1);
    bus.frame_ack = 1'b0;
    check("coinc_valid", bus.frame_valid, 1);
    check("coinc_hex", bus.hex_out, 32'h90FEDCBA);
    check("coinc_overrun", bus.overrun, 0);
    step(5);
    check("coinc_valid_hold", bus.frame_valid, 1);
    ack_pulse();

    // Decimal point handling
`ifdef SEG7_DP_CAPTURE_EN
    for (int i = 0; i < DIGITS; i++) begin
      bus.dp = (i == 2) ? 1'b0 : 1'b1;
      show(i, pat[1], 10);
    end
    bus.dp = 1'b1;
    check("dp_valid", bus.frame_valid, 1);
    check("dp_point", bus.point_out, 32'h04);
    check("dp_hex", bus.hex_out, 32'h11111111);
`else
    for (int i = 0; i < 7; i++) show(i, pat[1], 10);
    bus.an  = 8'h7F;
    bus.seg = pat[2];
    for (int k = 0; k < 10; k++) begin
      step(1);
      bus.dp = ~bus.dp;
    end
    bus.dp = 1'b1;
    check("dp_toggle_valid", bus.frame_valid, 1);
    check("dp_toggle_hex", bus.hex_out, 32'h21111111);
    check("dp_point_zero", bus.point_out, 0);
`endif

    // Reset in the middle of a partial frame
    ack_pulse();
    for (int i = 0; i < 4; i++) show(i, pat[5], 10);
    rst_n = 1'b0;
    #2;
    check("mid_rst_valid", bus.frame_valid, 0);
    check("mid_rst_hex", bus.hex_out, 0);
    check("mid_rst_blank", bus.blank_out, 0);
    check("mid_rst_point", bus.point_out, 0);
    check("mid_rst_overrun", bus.overrun, 0);
    step(2);
    rst_n = 1'b1;
    idle(10);
    for (int i = 4; i < 8; i++) show(i, pat[5], 10);
    check("partial_lost_valid", bus.frame_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
